// File: rtl/mac_pkg.sv
// Shared types and constants for the MAC sequencing controller.
package mac_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD_W = 2'd1,
      RUN    = 2'd2,
      DRAIN  = 2'd3
   } state_t;

   localparam logic [2:0] K1 = 3'd1;
   localparam logic [2:0] K3 = 3'd3;
   localparam logic [2:0] K5 = 3'd5;

   localparam logic [1:0] OP_MAC  = 2'd0;
   localparam logic [1:0] OP_MAX  = 2'd1;
   localparam logic [1:0] OP_AVG  = 2'd2;
   localparam logic [1:0] OP_PASS = 2'd3;

   localparam int MAC_LATENCY_DFLT = 2;

   // A job is legal when K is an odd supported size and the row is at least one window wide.
   function automatic logic cfg_legal(input logic [2:0] k, input logic [31:0] w,
                                      input logic [31:0] w_max);
      logic k_ok;
      k_ok = (k == K1) || (k == K3) || (k == K5);
      return k_ok && (w >= {29'd0, k}) && (w <= w_max);
   endfunction

endpackage

// File: rtl/mac_sched_if.sv
// Weight/column handshakes, MAC control pins and tagged result outputs.
interface mac_sched_if #(
   parameter int CNT_W = 6
);
   logic             w_valid;
   logic             w_ready;
   logic             col_valid;
   logic             col_ready;
   logic             stall;
   logic             mac_enable;
   logic             mac_load_weight;
   logic             mac_ifmaps_input_valid;
   logic             mac_load_ifmaps;
   logic [1:0]       mac_operation;
   logic [4:0]       mac_kernel_size;
   logic             out_valid;
   logic [CNT_W-1:0] out_col;

   modport master (
      input  w_valid, col_valid, stall,
      output w_ready, col_ready, mac_enable, mac_load_weight, mac_ifmaps_input_valid,
             mac_load_ifmaps, mac_operation, mac_kernel_size, out_valid, out_col
   );

   modport slave (
      output w_valid, col_valid, stall,
      input  w_ready, col_ready, mac_enable, mac_load_weight, mac_ifmaps_input_valid,
             mac_load_ifmaps, mac_operation, mac_kernel_size, out_valid, out_col
   );
endinterface

// File: rtl/mac_sched_tagpipe.sv
// Delay line carrying the output-column tag alongside the MAC pipeline.
module mac_sched_tagpipe
   import mac_pkg::*;
#(
   parameter int LAT   = MAC_LATENCY_DFLT,
   parameter int IDX_W = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_valid,
   input  logic [IDX_W-1:0] i_idx,
   output logic             o_valid,
   output logic [IDX_W-1:0] o_idx,
   output logic             o_any
);
   logic [LAT-1:0]   r_vld;
   logic [IDX_W-1:0] r_idx [LAT];

   // Stage 0 takes the new tag; later stages shift one step per cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vld <= '0;
         for (int i = 0; i < LAT; i++) r_idx[i] <= '0;
      end else begin
         r_vld[0] <= i_valid;
         r_idx[0] <= i_idx;
         for (int i = 1; i < LAT; i++) begin
            r_vld[i] <= r_vld[i-1];
            r_idx[i] <= r_idx[i-1];
         end
      end
   end

   assign o_valid = r_vld[LAT-1];
   assign o_idx   = r_idx[LAT-1];
   assign o_any   = |r_vld;
endmodule

// File: rtl/mac_sched.sv
// Sequences one weight load and one row-strip pass of the MAC, keeping its
// internal ifmap FIFO within bounds and tagging each result with its column.
module mac_sched
   import mac_pkg::*;
#(
   parameter int IFMAP_W_MAX = 32,
   parameter int CNT_W       = 6,
   parameter int FIFO_DEPTH  = 8,
   parameter int MAC_LATENCY = MAC_LATENCY_DFLT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_start,
   input  logic [2:0]       i_cfg_kernel_size,
   input  logic [1:0]       i_cfg_operation,
   input  logic [CNT_W-1:0] i_cfg_in_width,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_cfg_err,
   mac_sched_if.master      bus
);
   localparam int              FC_W    = $clog2(FIFO_DEPTH + 1);
   localparam logic [FC_W-1:0] FC_FULL = FC_W'(FIFO_DEPTH);

   state_t           r_state, w_state_nxt;
   logic [2:0]       r_k;
   logic [1:0]       r_op;
   logic [CNT_W-1:0] r_w;
   logic [CNT_W-1:0] r_push_cnt, r_pop_cnt;
   logic [FC_W-1:0]  r_fifo_cnt;
   logic             r_cfg_err;
   logic             w_legal, w_accept, w_push, w_pop, w_done;
   logic             w_wgt_ready, w_col_ready, w_tag_vld, w_pipe_any;
   logic [CNT_W-1:0] w_k_m1, w_tag_idx;

   assign w_legal  = cfg_legal(i_cfg_kernel_size, 32'(i_cfg_in_width), 32'(IFMAP_W_MAX));
   assign w_accept = (r_state == IDLE) && i_start && w_legal;
   assign w_push   = bus.col_valid && w_col_ready;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next state and handshake/pop decode.
   always_comb begin
      w_state_nxt = r_state;
      w_wgt_ready = 1'b0;
      w_col_ready = 1'b0;
      w_pop       = 1'b0;
      w_done      = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_accept) w_state_nxt = LOAD_W;
            else          w_state_nxt = IDLE;
         end
         LOAD_W: begin
            w_wgt_ready = 1'b1;
            if (bus.w_valid) w_state_nxt = RUN;
            else             w_state_nxt = LOAD_W;
         end
         RUN: begin
            // Full is judged before any same-cycle pop, so a push never races a pop.
            w_col_ready = (r_push_cnt < r_w) && (r_fifo_cnt < FC_FULL);
            w_pop       = (r_fifo_cnt != '0) && (r_pop_cnt < r_w) && !bus.stall;
            if (w_pop && ((r_pop_cnt + CNT_W'(1)) == r_w)) w_state_nxt = DRAIN;
            else                                           w_state_nxt = RUN;
         end
         DRAIN: begin
            if (!w_pipe_any) begin
               w_done      = 1'b1;
               w_state_nxt = IDLE;
            end else begin
               w_state_nxt = DRAIN;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Job configuration latch and illegal-config pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_k       <= 3'd0;
         r_w       <= '0;
         r_op      <= 2'd0;
         r_cfg_err <= 1'b0;
      end else begin
         r_cfg_err <= (r_state == IDLE) && i_start && !w_legal;
         if (w_accept) begin
            r_k  <= i_cfg_kernel_size;
            r_w  <= i_cfg_in_width;
            r_op <= i_cfg_operation;
         end
      end
   end

   // Push/pop/occupancy bookkeeping for the MAC-side FIFO.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_push_cnt <= '0;
         r_pop_cnt  <= '0;
         r_fifo_cnt <= '0;
      end else if (r_state == IDLE) begin
         r_push_cnt <= '0;
         r_pop_cnt  <= '0;
         r_fifo_cnt <= '0;
      end else begin
         if (w_push) r_push_cnt <= r_push_cnt + CNT_W'(1);
         if (w_pop)  r_pop_cnt  <= r_pop_cnt + CNT_W'(1);
         case ({w_push, w_pop})
            2'b10:   r_fifo_cnt <= r_fifo_cnt + FC_W'(1);
            2'b01:   r_fifo_cnt <= r_fifo_cnt - FC_W'(1);
            default: r_fifo_cnt <= r_fifo_cnt;
         endcase
      end
   end

   // The first K-1 pops only prime the window; later pops complete one output column.
   assign w_k_m1    = CNT_W'(r_k) - CNT_W'(1);
   assign w_tag_vld = w_pop && (r_pop_cnt >= w_k_m1);
   assign w_tag_idx = r_pop_cnt - w_k_m1;

   mac_sched_tagpipe #(
      .LAT   (MAC_LATENCY),
      .IDX_W (CNT_W)
   ) u_tagpipe (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_valid (w_tag_vld),
      .i_idx   (w_tag_idx),
      .o_valid (bus.out_valid),
      .o_idx   (bus.out_col),
      .o_any   (w_pipe_any)
   );

   assign o_busy                     = (r_state != IDLE);
   assign o_done                     = w_done;
   assign o_cfg_err                  = r_cfg_err;
   assign bus.w_ready                = w_wgt_ready;
   assign bus.col_ready              = w_col_ready;
   assign bus.mac_enable             = o_busy;
   assign bus.mac_load_weight        = bus.w_valid && w_wgt_ready;
   assign bus.mac_ifmaps_input_valid = w_push;
   assign bus.mac_load_ifmaps        = w_pop;
   assign bus.mac_operation          = r_op;
   assign bus.mac_kernel_size        = {2'b00, r_k};
endmodule

// File: tb/tb_mac_sched.sv
// Scoreboard bench for mac_sched: jobs push expected output columns, a monitor checks results and FIFO safety.
module tb_mac_sched;
   import mac_pkg::*;

   localparam int CNT_W = 6;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start;
   logic [2:0]       ks;
   logic [1:0]       op;
   logic [CNT_W-1:0] win;
   logic             busy, done, cfg_err;

   int total = 0;
   int bad   = 0;
   int exp_q[$];
   int exp_v;
   int m_cycle = 0, m_fifo = 0, m_peak = 0, m_k = 1;
   int m_pops = 0, m_pushes = 0, m_wloads = 0, m_dones = 0, m_errs = 0;
   int m_tag_cycle = 0, m_last_out = 0;

   always #5 clk = ~clk;

   mac_sched_if #(.CNT_W(CNT_W)) bus();

   mac_sched #(
      .IFMAP_W_MAX (32),
      .CNT_W       (CNT_W),
      .FIFO_DEPTH  (8),
      .MAC_LATENCY (2)
   ) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .i_start           (start),
      .i_cfg_kernel_size (ks),
      .i_cfg_operation   (op),
      .i_cfg_in_width    (win),
      .o_busy            (busy),
      .o_done            (done),
      .o_cfg_err         (cfg_err),
      .bus               (bus)
   );

   task automatic check(input string nm, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
      end
   endtask

   function automatic int outs_vec();
      return int'({busy, done, cfg_err, bus.w_ready, bus.col_ready, bus.mac_enable,
                   bus.mac_load_weight, bus.mac_ifmaps_input_valid, bus.mac_load_ifmaps,
                   bus.mac_operation, bus.mac_kernel_size, bus.out_valid, bus.out_col});
   endfunction

   // Monitor: FIFO occupancy model, result scoreboard, latency and done alignment.
   always @(negedge clk) begin
      if (!rst_n) begin
         m_fifo = 0;
      end else begin
         m_cycle++;
         if (bus.mac_load_ifmaps) begin
            check("pop_nonempty", (m_fifo > 0) ? 1 : 0, 1);
            if (m_pops == m_k - 1) m_tag_cycle = m_cycle;
            m_pops++;
         end
         if (bus.mac_ifmaps_input_valid) begin
            check("push_not_full", (m_fifo < 8) ? 1 : 0, 1);
            m_pushes++;
         end
         if (m_fifo == 8) check("ready_low_when_full", int'(bus.col_ready), 0);
         m_fifo = m_fifo + int'(bus.mac_ifmaps_input_valid) - int'(bus.mac_load_ifmaps);
         if (m_fifo > m_peak) m_peak = m_fifo;
         if (bus.mac_load_weight) m_wloads++;
         if (bus.out_valid) begin
            if (exp_q.size() == 0) begin
               check("out_unexpected", int'(bus.out_col), -1);
            end else begin
               exp_v = exp_q.pop_front();
               check("out_col", int'(bus.out_col), exp_v);
               if (exp_v == 0) check("out_latency", m_cycle - m_tag_cycle, 2);
            end
            m_last_out = m_cycle;
         end
         if (done) begin
            m_dones++;
            check("done_after_last_out", m_cycle - m_last_out, 1);
         end
         if (cfg_err) m_errs++;
      end
   end

   task automatic do_job(input int k, input int w, input int tog, input int stall_len,
                         input int poke, input int abort_at);
      int fin = 0;
      int seen_pop = 0;
      int stall_left = stall_len;
      m_k = k; m_pops = 0; m_pushes = 0; m_wloads = 0; m_dones = 0; m_errs = 0; m_peak = 0;
      for (int c = 0; c < w - k + 1; c++) exp_q.push_back(c);
      @(posedge clk); #1;
      ks = k[2:0]; win = w[CNT_W-1:0]; op = OP_AVG; start = 1'b1;
      bus.w_valid = 1'b1; bus.col_valid = 1'b0; bus.stall = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      for (int cyc = 0; cyc < 400 && fin == 0; cyc++) begin
         bus.col_valid = (tog != 0) ? (cyc % 2 == 1) : 1'b1;
         bus.stall     = (seen_pop != 0) && (stall_left > 0);
         start         = (cyc == poke);
         if (cyc == poke) begin
            ks  = 3'd1;
            win = 6'd1;
         end
         @(negedge clk);
         if (cyc == 0) check("w_handshake_first", int'(bus.mac_load_weight), 1);
         if (bus.stall) stall_left--;
         if (bus.mac_load_ifmaps) seen_pop = 1;
         if (done) fin = 1;
         if (cyc == abort_at) begin
            @(posedge clk); #1;
            rst_n = 1'b0; bus.col_valid = 1'b0; bus.w_valid = 1'b0; start = 1'b0;
            @(negedge clk);
            check("reset_midjob_outs", outs_vec(), 0);
            exp_q.delete();
            return;
         end
         @(posedge clk); #1;
      end
      start = 1'b0; bus.col_valid = 1'b0; bus.w_valid = 1'b0; bus.stall = 1'b0;
      check("job_done_seen", fin, 1);
      @(negedge clk);
      check("busy_after_done", int'(busy), 0);
      check("done_count", m_dones, 1);
      check("weight_loads", m_wloads, 1);
      check("push_total", m_pushes, w);
      check("pop_total", m_pops, w);
      check("results_left", exp_q.size(), 0);
      check("no_cfg_err_in_job", m_errs, 0);
   endtask

   task automatic illegal(input int k, input int w);
      @(posedge clk); #1;
      ks = k[2:0]; win = w[CNT_W-1:0]; op = OP_MAX; start = 1'b1;
      @(negedge clk);
      check("cfg_err_not_early", int'(cfg_err), 0);
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      check("cfg_err_pulse", int'(cfg_err), 1);
      check("busy_illegal", int'(busy), 0);
      @(posedge clk); #1;
      @(negedge clk);
      check("cfg_err_one_cycle", int'(cfg_err), 0);
      check("w_ready_illegal", int'(bus.w_ready), 0);
   endtask

   initial begin
      start = 1'b0; ks = 3'd0; op = 2'd0; win = '0;
      bus.w_valid = 1'b0; bus.col_valid = 1'b0; bus.stall = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_outs", outs_vec(), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      do_job(3, 5, 0, 0, -1, -1);
      do_job(3, 12, 0, 10, 4, -1);
      check("fifo_peak_full", m_peak, 8);
      do_job(5, 6, 1, 0, -1, -1);
      illegal(4, 8);
      illegal(5, 3);
      illegal(3, 33);
      do_job(1, 1, 0, 0, -1, -1);

      do_job(3, 8, 0, 0, -1, 6);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("outs_after_release", outs_vec(), 0);
      do_job(3, 5, 0, 0, -1, -1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end
endmodule

// File: doc/mac_sched.md
Name: mac_sched

Overview:
- Sequencing controller for one MAC unit: one 25-bit weight load, then one ifmap row-strip convolution pass.
- Accepts a job (kernel size, operation, ifmap width) from the layer controller and handshakes the weight buffer and the ifmap column supplier.
- Drives the MAC control pins so its internal ifmap FIFO never overflows or underflows.
- Emits a valid strobe and output-column index aligned with the MAC result.

Parameters:
IFMAP_W_MAX, 32, maximum ifmap width in columns
CNT_W, 6, counter width; must hold IFMAP_W_MAX
FIFO_DEPTH, 8, depth of the ifmap FIFO inside the MAC
MAC_LATENCY, 2, cycles from mac_load_ifmaps high to the matching MAC result valid

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  job request pulse; sampled in IDLE only
cfg_kernel_size  in  3  K; legal values 1, 3, 5
cfg_operation  in  2  passed to the MAC for the job
cfg_in_width  in  CNT_W  W, ifmap columns
busy  out  1  job in progress
done  out  1  1-cycle end-of-job pulse
cfg_err  out  1  1-cycle illegal-config pulse
w_valid  in  1  weight available
w_ready  out  1  weight accept
col_valid  in  1  ifmap column available
col_ready  out  1  column accept
stall  in  1  downstream hold; blocks FIFO pops
mac_enable  out  1  MAC enable
mac_load_weight  out  1  w_valid & w_ready
mac_ifmaps_input_valid  out  1  col_valid & col_ready
mac_load_ifmaps  out  1  FIFO pop / window shift
mac_operation  out  2  latched cfg_operation
mac_kernel_size  out  5  latched K, zero-extended
out_valid  out  1  MAC result valid this cycle
out_col  out  CNT_W  output column index of the current result

Behaviour:
- Reset is rst_n, asynchronous, active-low; clock is clk.
- All outputs and state reset to 0; FSM resets to IDLE. The MAC FIFO shares rst_n, so a reset mid-job leaves both sides empty and consistent.
- States and transitions:
  - IDLE -> LOAD_W on start with a legal config. Legal means K in {1,3,5} and K <= W <= IFMAP_W_MAX.
  - IDLE, start with an illegal config: cfg_err pulses next cycle and the FSM stays in IDLE.
  - start while not in IDLE is ignored.
  - The config is latched on the accepting start edge.
- LOAD_W: w_ready=1. On w_valid&w_ready, mac_load_weight=1 for that cycle, then -> RUN.
- busy=1 and mac_enable=1 in LOAD_W, RUN and DRAIN.
- Counters: push_cnt, pop_cnt (0..W), fifo_cnt (0..FIFO_DEPTH).
- col_ready=1 in RUN when push_cnt<W and fifo_cnt<FIFO_DEPTH. Full is conservative: no push when full even if a pop happens the same cycle.
- mac_load_ifmaps=1 in RUN when fifo_cnt>0, pop_cnt<W and stall=0.
- fifo_cnt update: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
- Output tagging: a pop with index p >= K-1 (0-based) produces output column p-K+1.
  - The tag travels down a MAC_LATENCY-stage valid/index shift register.
  - out_valid and out_col are driven from the last stage.
  - A job produces exactly W-K+1 results, with out_col ascending from 0.
- RUN -> DRAIN when pop_cnt reaches W.
- DRAIN: wait until the shift register is empty. done pulses in the cycle after the last out_valid, then -> IDLE with busy=0. start is accepted in the cycle after done.
- stall only gates pops. Results already in the pipeline still emerge.
- Pushes continue while stalled until the FIFO is full.
- col_valid or w_valid outside their states is ignored (ready=0).

Decomposition:
- Shared package mac_pkg holds:
  - state enum (IDLE, LOAD_W, RUN, DRAIN);
  - legal kernel constants K1=1, K3=3, K5=5;
  - OP_* operation codes;
  - the MAC_LATENCY default.
- One sub-module: mac_sched_tagpipe, a MAC_LATENCY-deep valid+index delay line.

Test Plan:
- K=3, W=5, col_valid and w_valid always high, stall=0:
  - weight handshake in the first LOAD_W cycle;
  - 5 pushes and 5 pops;
  - out_valid on 3 cycles with out_col 0,1,2, the first exactly MAC_LATENCY cycles after the 3rd pop;
  - done once, then busy=0.
- K=3, W=12, stall high for 10 cycles after the first pop:
  - col_ready drops when fifo_cnt=8 and the FIFO never overflows;
  - after release, pops resume and out_col 0..9 arrive in order with no gaps or duplicates.
- K=5, W=6, col_valid toggling every other cycle:
  - mac_load_ifmaps never asserts with fifo_cnt=0;
  - exactly 2 results, out_col 0 then 1.
- Illegal configs: K=4, W=8 -> cfg_err pulse, busy stays 0; K=5, W=3 -> cfg_err; W=33 -> cfg_err; start while busy -> no effect on the job.
- Edge case K=1, W=1: one pop, out_valid with out_col=0, then done.
- Reset mid-job: assert rst_n low during RUN -> all outputs 0 and FSM in IDLE; a following legal job completes normally.
